// File: rtl/abortable_timer_bank_if.sv
// ---------------------------------------------------------------------------
// abortable_timer_bank_if
//   Bundles the control and status signals of abortable_timer_bank.
//   The master (sequencing controller) drives start/abort/delay and reads the
//   status. The slave (the timer bank) does the reverse.
//
//   Signals:
//     start       NCH        per-channel start request
//     abort       NCH        per-channel cancel request
//     abort_all   1          cancel every channel (only with ATB_ABORT_ALL_EN)
//     delay       NCH*CW     channel i delay in bits [i*CW +: CW]
//     busy        NCH        channel i is running
//     done        NCH        one-cycle pulse, channel expired normally
//     aborted     NCH        one-cycle pulse, channel cancelled while running
//     active_cnt  clog2(NCH+1) number of running channels
//
//   Optional feature macro: ATB_ABORT_ALL_EN (adds abort_all).
// ---------------------------------------------------------------------------
interface abortable_timer_bank_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    logic [NCH-1:0]              start;
    logic [NCH-1:0]              abort;
`ifdef ATB_ABORT_ALL_EN
    logic                        abort_all;
`endif
    logic [NCH*CW-1:0]           delay;
    logic [NCH-1:0]              busy;
    logic [NCH-1:0]              done;
    logic [NCH-1:0]              aborted;
    logic [$clog2(NCH+1)-1:0]    active_cnt;

`ifdef ATB_ABORT_ALL_EN
    modport master (output start, abort, abort_all, delay,
                    input  busy, done, aborted, active_cnt);
    modport slave  (input  start, abort, abort_all, delay,
                    output busy, done, aborted, active_cnt);
`else
    modport master (output start, abort, delay,
                    input  busy, done, aborted, active_cnt);
    modport slave  (input  start, abort, delay,
                    output busy, done, aborted, active_cnt);
`endif
endinterface

// File: rtl/abortable_timer_bank.sv
// ---------------------------------------------------------------------------
// abortable_timer_bank
//   Bank of NCH independent countdown timers. Each channel can be started,
//   retriggered and cancelled. A cancelled channel never produces done.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    abortable_timer_bank_if.slave (start/abort/delay in,
//            busy/done/aborted/active_cnt out, all outputs registered)
//
//   Parameters: NCH (1..32) channels, CW counter/delay width.
//   Optional feature macro: ATB_ABORT_ALL_EN adds bus.abort_all, which acts
//   as abort on every channel in the same cycle.
// ---------------------------------------------------------------------------
module abortable_timer_bank #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    abortable_timer_bank_if.slave  bus
);
    localparam int AW = $clog2(NCH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [NCH-1:0] abort_eff;
    logic [NCH-1:0] busy_next;
    logic [NCH-1:0] done_next;
    logic [NCH-1:0] aborted_next;
    logic [NCH-1:0] busy_reg;
    logic [NCH-1:0] done_reg;
    logic [NCH-1:0] aborted_reg;
    logic [AW-1:0]  active_cnt_reg;
    logic [AW-1:0]  active_cnt_next;

`ifdef ATB_ABORT_ALL_EN
    assign abort_eff = bus.abort | {NCH{bus.abort_all}};
`else
    assign abort_eff = bus.abort;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t         state_reg;
            state_t         state_next;
            logic [CW-1:0]  cnt_reg;
            logic [CW-1:0]  cnt_next;
            logic [CW-1:0]  delay_ch;
            logic           done_ch;
            logic           aborted_ch;

            assign delay_ch = bus.delay[gi*CW +: CW];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Abort always beats start, in both states; in RUN it also beats
            // expiry so an abort on the last edge reports aborted, not done.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                done_ch    = 1'b0;
                aborted_ch = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (bus.start[gi] && !abort_eff[gi]) begin
                            state_next = RUN;
                            cnt_next   = delay_ch;
                        end
                    end
                    RUN: begin
                        if (abort_eff[gi]) begin
                            state_next = IDLE;
                            aborted_ch = 1'b1;
                        end else if (bus.start[gi]) begin
                            cnt_next   = delay_ch;
                        end else if (cnt_reg == '0) begin
                            state_next = IDLE;
                            done_ch    = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            assign busy_next[gi]    = (state_next == RUN);
            assign done_next[gi]    = done_ch;
            assign aborted_next[gi] = aborted_ch;
        end
    endgenerate

    // Popcount of the next busy vector so active_cnt lines up with busy.
    always_comb begin
        active_cnt_next = '0;
        for (int i = 0; i < NCH; i++) begin
            active_cnt_next = active_cnt_next + AW'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg       <= '0;
            done_reg       <= '0;
            aborted_reg    <= '0;
            active_cnt_reg <= '0;
        end else begin
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            aborted_reg    <= aborted_next;
            active_cnt_reg <= active_cnt_next;
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.aborted    = aborted_reg;
    assign bus.active_cnt = active_cnt_reg;

endmodule

// File: tb/tb_abortable_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_abortable_timer_bank
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A deadline-based reference model (each running channel holds the
//   absolute edge number on which it expires) is compared with the DUT on
//   every falling edge.
// ---------------------------------------------------------------------------
module tb_abortable_timer_bank;
    localparam int NCH = 4;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    abortable_timer_bank_if #(.NCH(NCH), .CW(CW)) bus ();

    abortable_timer_bank #(.NCH(NCH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [NCH-1:0] m_run = '0;
    logic [NCH-1:0] m_done = '0;
    logic [NCH-1:0] m_abt = '0;
    longint         m_end [NCH];
    longint         edge_no = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= '0;
            m_done <= '0;
            m_abt  <= '0;
        end else begin
            logic [NCH-1:0] r, d, a;
            longint         e [NCH];
            logic           ab;
            r = m_run;
            d = '0;
            a = '0;
            for (int i = 0; i < NCH; i++) begin
                e[i] = m_end[i];
                ab   = bus.abort[i];
`ifdef ATB_ABORT_ALL_EN
                ab   = ab | bus.abort_all;
`endif
                if (r[i]) begin
                    if (ab) begin
                        r[i] = 1'b0;
                        a[i] = 1'b1;
                    end else if (bus.start[i]) begin
                        e[i] = edge_no + longint'(bus.delay[i*CW +: CW]) + 1;
                    end else if (edge_no == e[i]) begin
                        r[i] = 1'b0;
                        d[i] = 1'b1;
                    end
                end else if (bus.start[i] && !ab) begin
                    r[i] = 1'b1;
                    e[i] = edge_no + longint'(bus.delay[i*CW +: CW]) + 1;
                end
            end
            m_run   <= r;
            m_done  <= d;
            m_abt   <= a;
            m_end   <= e;
            edge_no <= edge_no + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare the DUT against the model.
    task automatic cycle();
        @(negedge clk);
        chk("model_busy",       longint'(bus.busy),       longint'(m_run));
        chk("model_done",       longint'(bus.done),       longint'(m_done));
        chk("model_aborted",    longint'(bus.aborted),    longint'(m_abt));
        chk("model_active_cnt", longint'(bus.active_cnt), longint'($countones(m_run)));
    endtask

    task automatic clear_inputs();
        bus.start = '0;
        bus.abort = '0;
`ifdef ATB_ABORT_ALL_EN
        bus.abort_all = 1'b0;
`endif
    endtask

    // Start channel ch with delay d (optionally with abort on the same edge),
    // then observe it for ncyc samples. Sample 0 is the first falling edge
    // after the start edge. abort_i / restart_i name the sample at which an
    // abort or a retrigger is driven (-1 = never).
    task automatic measure(input int ch, input int d, input bit abort_too,
                           input int abort_i, input int restart_i, input int restart_d,
                           input int ncyc,
                           output int busy_n, output int done_at,
                           output int abt_at, output int act0);
        bus.start[ch]             = 1'b1;
        bus.abort[ch]             = abort_too;
        bus.delay[ch*CW +: CW]    = CW'(d);
        cycle();
        clear_inputs();
        busy_n  = 0;
        done_at = -1;
        abt_at  = -1;
        act0    = int'(bus.active_cnt);
        for (int i = 0; i < ncyc; i++) begin
            if (bus.busy[ch]) busy_n++;
            if (bus.done[ch] && done_at < 0) done_at = i;
            if (bus.aborted[ch] && abt_at < 0) abt_at = i;
            if (i == abort_i) bus.abort[ch] = 1'b1;
            if (i == restart_i) begin
                bus.start[ch]          = 1'b1;
                bus.delay[ch*CW +: CW] = CW'(restart_d);
            end
            cycle();
            clear_inputs();
        end
    endtask

    initial begin
        int busy_n, done_at, abt_at, act0, pulses;

        rst_n     = 1'b0;
        bus.delay = '0;
        clear_inputs();
        repeat (3) cycle();
        chk("reset_busy",       longint'(bus.busy), 0);
        chk("reset_done",       longint'(bus.done), 0);
        chk("reset_aborted",    longint'(bus.aborted), 0);
        chk("reset_active_cnt", longint'(bus.active_cnt), 0);
        rst_n = 1'b1;
        cycle();

        // 1: ch0, D=3
        measure(0, 3, 1'b0, -1, -1, 0, 10, busy_n, done_at, abt_at, act0);
        $display("T1 ch0 D=3: busy=%0d done_at=%0d aborted_at=%0d act0=%0d", busy_n, done_at, abt_at, act0);
        chk("t1_busy_cycles", busy_n, 4);
        chk("t1_done_at", done_at, 4);
        chk("t1_aborted_at", abt_at, -1);
        chk("t1_active_cnt", act0, 1);

        // 2: ch1, D=10, abort 4 cycles after start
        measure(1, 10, 1'b0, 3, -1, 0, 16, busy_n, done_at, abt_at, act0);
        $display("T2 ch1 D=10 abort: busy=%0d done_at=%0d aborted_at=%0d", busy_n, done_at, abt_at);
        chk("t2_busy_cycles", busy_n, 4);
        chk("t2_aborted_at", abt_at, 4);
        chk("t2_done_at", done_at, -1);

        // 3: ch2, D=5, abort on the expiry edge
        measure(2, 5, 1'b0, 5, -1, 0, 12, busy_n, done_at, abt_at, act0);
        $display("T3 ch2 D=5 abort@expiry: busy=%0d done_at=%0d aborted_at=%0d", busy_n, done_at, abt_at);
        chk("t3_busy_cycles", busy_n, 6);
        chk("t3_aborted_at", abt_at, 6);
        chk("t3_done_at", done_at, -1);

        // 3b: start and abort on the same edge while idle
        measure(2, 5, 1'b1, -1, -1, 0, 10, busy_n, done_at, abt_at, act0);
        $display("T3b ch2 start+abort idle: busy=%0d done_at=%0d aborted_at=%0d", busy_n, done_at, abt_at);
        chk("t3b_busy_cycles", busy_n, 0);
        chk("t3b_aborted_at", abt_at, -1);
        chk("t3b_done_at", done_at, -1);

        // 4: ch3, D=6, retrigger with D=2 after 3 cycles
        measure(3, 6, 1'b0, -1, 2, 2, 12, busy_n, done_at, abt_at, act0);
        $display("T4 ch3 retrigger: busy=%0d done_at=%0d aborted_at=%0d", busy_n, done_at, abt_at);
        chk("t4_busy_cycles", busy_n, 6);
        chk("t4_done_at", done_at, 6);

        // Boundaries: D=0 and D=max
        measure(0, 0, 1'b0, -1, -1, 0, 5, busy_n, done_at, abt_at, act0);
        $display("TB0 ch0 D=0: busy=%0d done_at=%0d", busy_n, done_at);
        chk("d0_busy_cycles", busy_n, 1);
        chk("d0_done_at", done_at, 1);
        measure(1, 255, 1'b0, -1, -1, 0, 262, busy_n, done_at, abt_at, act0);
        $display("TBMAX ch1 D=255: busy=%0d done_at=%0d", busy_n, done_at);
        chk("dmax_busy_cycles", busy_n, 256);
        chk("dmax_done_at", done_at, 256);

        // 5: all channels D=255, reset mid-run
        bus.start = '1;
        bus.delay = {NCH{8'd255}};
        cycle();
        clear_inputs();
        repeat (20) cycle();
        chk("t5_active_before", longint'(bus.active_cnt), NCH);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy_in_reset",       longint'(bus.busy), 0);
        chk("t5_active_in_reset",     longint'(bus.active_cnt), 0);
        chk("t5_done_in_reset",       longint'(bus.done), 0);
        chk("t5_aborted_in_reset",    longint'(bus.aborted), 0);
        cycle();
        cycle();
        #2 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            pulses += $countones(bus.done) + $countones(bus.aborted);
        end
        $display("T5 reset mid-run: pulses_after_release=%0d active=%0d", pulses, bus.active_cnt);
        chk("t5_pulses_after_release", pulses, 0);
        chk("t5_active_after", longint'(bus.active_cnt), 0);

`ifdef ATB_ABORT_ALL_EN
        // 6: abort_all with ch0/ch2 running, ch1 idle
        bus.start = 4'b0101;
        bus.delay = {NCH{8'd50}};
        cycle();
        clear_inputs();
        repeat (3) cycle();
        bus.abort_all = 1'b1;
        cycle();
        clear_inputs();
        $display("T6 abort_all: aborted=%b busy=%b active=%0d", bus.aborted, bus.busy, bus.active_cnt);
        chk("t6_aborted", longint'(bus.aborted), 5);
        chk("t6_busy", longint'(bus.busy), 0);
        chk("t6_active_cnt", longint'(bus.active_cnt), 0);
        cycle();
`endif

        // Randomized traffic, every cycle compared against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                int sel;
                bus.start[i] = ($urandom_range(0, 5) == 0);
                bus.abort[i] = ($urandom_range(0, 19) == 0);
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      bus.delay[i*CW +: CW] = '0;
                else if (sel == 1) bus.delay[i*CW +: CW] = '1;
                else               bus.delay[i*CW +: CW] = CW'($urandom_range(1, 15));
            end
`ifdef ATB_ABORT_ALL_EN
            bus.abort_all = ($urandom_range(0, 199) == 0);
`endif
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                cycle();
                #2 rst_n = 1'b1;
            end
            cycle();
        end
        clear_inputs();
        repeat (5) cycle();
        $display("RANDOM phase complete: 3000 cycles");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
